// File: rtl/lmi_dcache_seq.sv
// Data-cache sequencer for the LMI data cache: lookup, invalidate sweep,
// dirty eviction, critical-word-first fill and uncached read control.
module lmi_dcache_seq #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64,
    parameter int WB_EN      = 0,
    localparam int CTR_W     = $clog2(LINE_WORDS),
    localparam int IDX_W     = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_op,
    input  logic             wr_op,
    input  logic             hit,
    input  logic             victim_dirty,
    input  logic             uncached,
    input  logic             cache_off,
    input  logic             other_busy,
    input  logic             excp,
    input  logic             inval_req,
    input  logic [CTR_W-1:0] crit_word,
    input  logic             bus_gnt,
    input  logic             ds_val,
    input  logic             wr_ack,
    output logic [8:0]       state,
    output logic             busy,
    output logic             bus_req,
    output logic             bus_wr,
    output logic [CTR_W-1:0] beat_idx,
    output logic             fill_we,
    output logic             crit_val,
    output logic             evict_re,
    output logic             inv_we,
    output logic [IDX_W-1:0] inv_idx,
    output logic             done
);

    typedef enum logic [8:0] {
        S_LOOKUP    = 9'b000000001,
        S_INVAL     = 9'b000000010,
        S_EVICT_REQ = 9'b000000100,
        S_EVICT     = 9'b000001000,
        S_MISS_REQ  = 9'b000010000,
        S_FILL      = 9'b000100000,
        S_REPLAY    = 9'b001000000,
        S_UCREQ     = 9'b010000000,
        S_UCWAIT    = 9'b100000000
    } state_t;

    localparam logic WB_ON = (WB_EN != 0);
    localparam logic [CTR_W-1:0] LAST_BEAT = CTR_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);

    state_t           state_r;
    logic [CTR_W-1:0] beat_idx_r;
    logic [CTR_W-1:0] beat_cnt_r;
    logic [IDX_W-1:0] inv_idx_r;

    logic uc_s;
    logic any_op_s;
    logic alloc_s;

    assign uc_s     = uncached | cache_off;
    assign any_op_s = rd_op | wr_op;
    // Write misses only allocate a line when running write-back.
    assign alloc_s  = rd_op | (wr_op & WB_ON);

    // Sequencer state, beat/fill counters and invalidate sweep index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_INVAL;
            beat_idx_r <= {CTR_W{1'b0}};
            beat_cnt_r <= {CTR_W{1'b0}};
            inv_idx_r  <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                S_INVAL: begin
                    if (inv_idx_r == LAST_SET) begin
                        inv_idx_r <= {IDX_W{1'b0}};
                        state_r   <= S_LOOKUP;
                    end else begin
                        inv_idx_r <= inv_idx_r + IDX_W'(1);
                    end
                end
                S_LOOKUP: begin
                    if (excp | other_busy) begin
                        state_r <= S_LOOKUP;
                    end else if (rd_op & uc_s) begin
                        state_r <= S_UCREQ;
                    end else if (wr_op & uc_s) begin
                        state_r <= S_LOOKUP;
                    end else if (any_op_s & hit) begin
                        state_r <= S_LOOKUP;
                    end else if (alloc_s) begin
                        state_r <= (WB_ON & victim_dirty) ? S_EVICT_REQ : S_MISS_REQ;
                    end else if (!any_op_s && inval_req) begin
                        state_r   <= S_INVAL;
                        inv_idx_r <= {IDX_W{1'b0}};
                    end else begin
                        state_r <= S_LOOKUP;
                    end
                end
                S_EVICT_REQ: begin
                    if (bus_gnt) begin
                        state_r    <= S_EVICT;
                        beat_idx_r <= {CTR_W{1'b0}};
                    end else begin
                        state_r <= S_EVICT_REQ;
                    end
                end
                S_EVICT: begin
                    if (wr_ack) begin
                        beat_idx_r <= beat_idx_r + CTR_W'(1);
                        state_r    <= (beat_idx_r == LAST_BEAT) ? S_MISS_REQ : S_EVICT;
                    end else begin
                        state_r <= S_EVICT;
                    end
                end
                S_MISS_REQ: begin
                    if (bus_gnt) begin
                        state_r    <= S_FILL;
                        beat_idx_r <= crit_word;
                        beat_cnt_r <= {CTR_W{1'b0}};
                    end else begin
                        state_r <= S_MISS_REQ;
                    end
                end
                S_FILL: begin
                    // Power-of-two line: natural overflow gives the wrapping burst order.
                    if (ds_val) begin
                        beat_idx_r <= beat_idx_r + CTR_W'(1);
                        beat_cnt_r <= beat_cnt_r + CTR_W'(1);
                        state_r    <= (beat_cnt_r == LAST_BEAT) ? S_REPLAY : S_FILL;
                    end else begin
                        state_r <= S_FILL;
                    end
                end
                S_REPLAY: begin
                    state_r <= S_LOOKUP;
                end
                S_UCREQ: begin
                    state_r <= bus_gnt ? S_UCWAIT : S_UCREQ;
                end
                S_UCWAIT: begin
                    state_r <= ds_val ? S_LOOKUP : S_UCWAIT;
                end
                default: begin
                    state_r    <= S_INVAL;
                    beat_idx_r <= {CTR_W{1'b0}};
                    beat_cnt_r <= {CTR_W{1'b0}};
                    inv_idx_r  <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign state    = state_r;
    assign busy     = (state_r != S_LOOKUP);
    assign bus_req  = (state_r == S_EVICT_REQ) | (state_r == S_MISS_REQ) | (state_r == S_UCREQ);
    assign bus_wr   = (state_r == S_EVICT_REQ);
    assign beat_idx = beat_idx_r;
    assign evict_re = (state_r == S_EVICT);
    assign fill_we  = (state_r == S_FILL) & ds_val;
    assign crit_val = (state_r == S_FILL) & ds_val & (beat_cnt_r == {CTR_W{1'b0}});
    assign inv_we   = (state_r == S_INVAL);
    assign inv_idx  = inv_idx_r;
    assign done     = (state_r == S_REPLAY) | ((state_r == S_UCWAIT) & ds_val);

endmodule

// File: tb/tb_lmi_dcache_seq.sv
// Directed bench for lmi_dcache_seq: one write-back and one write-through
// instance driven by the same stimulus, vector table plus corner sequences.
module tb_lmi_dcache_seq;

    localparam logic [8:0] LK = 9'h001, IV = 9'h002, ER = 9'h004, EV = 9'h008,
                           MR = 9'h010, FL = 9'h020, RP = 9'h040, UR = 9'h080,
                           UW = 9'h100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rd, wr, hit, dirty, unc, coff, excp, obusy, ireq, gnt, ds, ack;
    logic [1:0] crit;

    logic [8:0] st_b, st_t;
    logic       busy_b, breq_b, bwr_b, fwe_b, cval_b, ere_b, invwe_b, done_b;
    logic [1:0] beat_b;
    logic [5:0] invidx_b;
    logic       busy_t, breq_t, bwr_t, fwe_t, cval_t, ere_t, invwe_t, done_t;
    logic [1:0] beat_t;
    logic [5:0] invidx_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lmi_dcache_seq #(.LINE_WORDS(4), .SETS(64), .WB_EN(1)) dut_wb (
        .clk(clk), .reset(reset), .rd_op(rd), .wr_op(wr), .hit(hit),
        .victim_dirty(dirty), .uncached(unc), .cache_off(coff),
        .other_busy(obusy), .excp(excp), .inval_req(ireq), .crit_word(crit),
        .bus_gnt(gnt), .ds_val(ds), .wr_ack(ack), .state(st_b), .busy(busy_b),
        .bus_req(breq_b), .bus_wr(bwr_b), .beat_idx(beat_b), .fill_we(fwe_b),
        .crit_val(cval_b), .evict_re(ere_b), .inv_we(invwe_b),
        .inv_idx(invidx_b), .done(done_b)
    );

    lmi_dcache_seq #(.LINE_WORDS(4), .SETS(64), .WB_EN(0)) dut_wt (
        .clk(clk), .reset(reset), .rd_op(rd), .wr_op(wr), .hit(hit),
        .victim_dirty(dirty), .uncached(unc), .cache_off(coff),
        .other_busy(obusy), .excp(excp), .inval_req(ireq), .crit_word(crit),
        .bus_gnt(gnt), .ds_val(ds), .wr_ack(ack), .state(st_t), .busy(busy_t),
        .bus_req(breq_t), .bus_wr(bwr_t), .beat_idx(beat_t), .fill_we(fwe_t),
        .crit_val(cval_t), .evict_re(ere_t), .inv_we(invwe_t),
        .inv_idx(invidx_t), .done(done_t)
    );

    // ins = {rd,wr,hit,dirty, unc,coff,excp,obusy, ireq,gnt,ds,ack}
    // outs = {bus_req,bus_wr,fill_we,crit_val,evict_re,done}
    typedef struct {
        logic [11:0] ins;
        logic [1:0]  crit;
        logic [8:0]  st;
        logic [8:0]  st_wt;
        logic [5:0]  outs;
        logic [1:0]  beat;
        bit          chkb;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic [11:0] ins, input logic [1:0] c,
                              input logic [8:0] s, input logic [8:0] swt,
                              input logic [5:0] o, input logic [1:0] b, input bit cb);
        vec_t r;
        r.ins = ins; r.crit = c; r.st = s; r.st_wt = swt; r.outs = o; r.beat = b; r.chkb = cb;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic clr_inputs();
        {rd, wr, hit, dirty, unc, coff, excp, obusy, ireq, gnt, ds, ack} = 12'b0;
        crit = 2'd0;
    endtask

    initial begin
        clr_inputs();
        // Clean read miss, critical word 2, back-to-back beats.
        v(12'b1000_0000_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b1);
        v(12'b0000_0000_0000, 2'd0, MR, MR, 6'b100000, 2'd0, 1'b1);
        v(12'b0000_0000_0100, 2'd2, MR, MR, 6'b100000, 2'd0, 1'b1);
        v(12'b0000_0000_0010, 2'd0, FL, FL, 6'b001100, 2'd2, 1'b1);
        v(12'b0000_0000_0010, 2'd0, FL, FL, 6'b001000, 2'd3, 1'b1);
        v(12'b0000_0000_0010, 2'd0, FL, FL, 6'b001000, 2'd0, 1'b1);
        v(12'b0000_0000_0010, 2'd0, FL, FL, 6'b001000, 2'd1, 1'b1);
        v(12'b0000_0000_0000, 2'd0, RP, RP, 6'b000001, 2'd0, 1'b0);
        v(12'b0000_0000_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        // Hit, write-through store, exception and other-busy holds, stray bus inputs.
        v(12'b1010_0000_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        v(12'b0100_1000_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        v(12'b1000_0010_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        v(12'b1000_0001_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        v(12'b0000_0000_0111, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        // Uncached read (cache off), data five cycles after grant.
        v(12'b1000_0100_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        v(12'b0000_0000_0000, 2'd0, UR, UR, 6'b100000, 2'd0, 1'b0);
        v(12'b0000_0000_0100, 2'd0, UR, UR, 6'b100000, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            v(12'b0000_0000_0000, 2'd0, UW, UW, 6'b000000, 2'd0, 1'b0);
        v(12'b0000_0000_0010, 2'd0, UW, UW, 6'b000001, 2'd0, 1'b0);
        v(12'b0000_0000_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        // Dirty write miss: write-back evicts, write-through stays in lookup.
        v(12'b0101_0000_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        v(12'b0000_0000_0000, 2'd0, ER, LK, 6'b110000, 2'd0, 1'b0);
        v(12'b0000_0000_0100, 2'd0, ER, LK, 6'b110000, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            v(12'b0000_0000_0000, 2'd0, EV, LK, 6'b000010, 2'(i), 1'b1);
            v(12'b0000_0000_0001, 2'd0, EV, LK, 6'b000010, 2'(i), 1'b1);
        end
        v(12'b0000_0000_0100, 2'd0, MR, LK, 6'b100000, 2'd0, 1'b0);
        v(12'b0000_0000_0010, 2'd0, FL, LK, 6'b001100, 2'd0, 1'b1);
        v(12'b0000_0000_0010, 2'd0, FL, LK, 6'b001000, 2'd1, 1'b1);
        v(12'b0000_0000_0010, 2'd0, FL, LK, 6'b001000, 2'd2, 1'b1);
        v(12'b0000_0000_0010, 2'd0, FL, LK, 6'b001000, 2'd3, 1'b1);
        v(12'b0000_0000_0000, 2'd0, RP, LK, 6'b000001, 2'd0, 1'b0);
        v(12'b0000_0000_0000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        // Invalidate request waits while an op is present.
        v(12'b1010_0000_1000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        v(12'b0000_0000_1000, 2'd0, LK, LK, 6'b000000, 2'd0, 1'b0);
        v(12'b0000_0000_0000, 2'd0, IV, IV, 6'b000000, 2'd0, 1'b0);

        // Reset values and the power-up sweep.
        #1 reset = 1'b1;
        #2;
        chk("rst_state", 32'(st_b), 32'(IV));
        chk("rst_busy", 32'(busy_b), 32'd1);
        chk("rst_inv_we", 32'(invwe_b), 32'd1);
        chk("rst_inv_idx", 32'(invidx_b), 32'd0);
        chk("rst_outs", 32'({breq_b, bwr_b, fwe_b, cval_b, ere_b, done_b, beat_b}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            chk($sformatf("sweep_idx%0d", i), 32'({invwe_b, invidx_b}), 32'({1'b1, 6'(i)}));
            @(negedge clk);
        end
        #1;
        chk("sweep_end_state", 32'(st_b), 32'(LK));
        chk("sweep_end_busy", 32'(busy_b), 32'd0);

        foreach (vecs[k]) begin
            @(negedge clk);
            {rd, wr, hit, dirty, unc, coff, excp, obusy, ireq, gnt, ds, ack} = vecs[k].ins;
            crit = vecs[k].crit;
            #1;
            chk($sformatf("vec%0d_state", k), 32'(st_b), 32'(vecs[k].st));
            chk($sformatf("vec%0d_state_wt", k), 32'(st_t), 32'(vecs[k].st_wt));
            chk($sformatf("vec%0d_outs", k),
                32'({breq_b, bwr_b, fwe_b, cval_b, ere_b, done_b}), 32'(vecs[k].outs));
            chk($sformatf("vec%0d_busy", k), 32'(busy_b), 32'(vecs[k].st != LK));
            if (vecs[k].chkb)
                chk($sformatf("vec%0d_beat", k), 32'(beat_b), 32'(vecs[k].beat));
        end

        // Requested sweep: the table's last row was index 0.
        chk("inval_idx0", 32'({invwe_b, invidx_b}), 32'({1'b1, 6'd0}));
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("inval_idx%0d", i), 32'(invidx_b), 32'(i));
        end
        @(negedge clk);
        #1;
        chk("inval_end_state", 32'(st_b), 32'(LK));

        // Exception and other-busy asserted through a fill: fill runs to completion.
        @(negedge clk); clr_inputs(); rd = 1'b1;
        @(negedge clk); rd = 1'b0; gnt = 1'b1; crit = 2'd1;
        #1 chk("excp_fill_req", 32'(st_b), 32'(MR));
        @(negedge clk); gnt = 1'b0; ds = 1'b1; excp = 1'b1; obusy = 1'b1; rd = 1'b1; crit = 2'd0;
        #1 chk("excp_fill_b0", 32'({st_b, cval_b, beat_b}), 32'({FL, 1'b1, 2'd1}));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            #1 chk($sformatf("excp_fill_b%0d", i), 32'({st_b, cval_b, beat_b}),
                   32'({FL, 1'b0, 2'((1 + i) % 4)}));
        end
        @(negedge clk); clr_inputs();
        #1 chk("excp_fill_replay", 32'({st_b, done_b}), 32'({RP, 1'b1}));
        @(negedge clk);
        #1 chk("excp_fill_lookup", 32'(st_b), 32'(LK));

        // Reset on the third fill beat.
        @(negedge clk); rd = 1'b1;
        @(negedge clk); rd = 1'b0; gnt = 1'b1; crit = 2'd3;
        @(negedge clk); gnt = 1'b0; ds = 1'b1;
        #1 chk("rstfill_b0", 32'({st_b, beat_b}), 32'({FL, 2'd3}));
        @(negedge clk);
        @(negedge clk);
        #1 chk("rstfill_b2", 32'({st_b, beat_b}), 32'({FL, 2'd1}));
        #1 reset = 1'b1;
        #1;
        chk("rstfill_state", 32'(st_b), 32'(IV));
        chk("rstfill_outs", 32'({breq_b, fwe_b, beat_b, invidx_b}), 32'd0);
        @(negedge clk); reset = 1'b0; ds = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("rstfill_sweep%0d", i), 32'({invwe_b, invidx_b}), 32'({1'b1, 6'(i)}));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
